// File: rtl/hdmi_blk_buf_ctrl_if.sv
// Signal bundle between the HDMI pixel front end, the two 8-line bank RAMs and the block datapath.
// The master drives the HDMI/ready side; the slave (the sequencer) drives RAM strobes and block flags.
interface hdmi_blk_buf_ctrl_if #(
    parameter int AW = 6
);
    logic          en;
    logic          hdmi_v_sync;
    logic          hdmi_h_sync;
    logic          hdmi_data_valid;
    logic          blk_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          blk_valid;
    logic          blk_sob;
    logic          blk_eob;
    logic          blk_sof;
    logic          ovf_err;

    modport master (
        output en, hdmi_v_sync, hdmi_h_sync, hdmi_data_valid, blk_ready,
        input  wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
               blk_valid, blk_sob, blk_eob, blk_sof, ovf_err
    );

    modport slave (
        input  en, hdmi_v_sync, hdmi_h_sync, hdmi_data_valid, blk_ready,
        output wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
               blk_valid, blk_sob, blk_eob, blk_sof, ovf_err
    );
endinterface

// File: rtl/hdmi_blk_buf_ctrl.sv
// Ping-pong 8-line buffer sequencer: raster pixel beats are written into one bank while the
// other bank is read back in 8x8 block order; emits RAM addresses and aligned block flags.
module hdmi_blk_buf_ctrl #(
    parameter int N     = 2,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200
) (
    input  logic               clk,
    input  logic               rst,
    hdmi_blk_buf_ctrl_if.slave bus
);
    localparam int W   = X_RES / N;
    localparam int D   = 8 * W;
    localparam int AW  = $clog2(D);
    localparam int WPB = 8 / N;
    localparam int NB  = X_RES / 8;
    localparam int CW  = (W   > 1) ? $clog2(W)   : 1;
    localparam int WW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BW  = (NB  > 1) ? $clog2(NB)  : 1;

    if ((8 % N != 0) || (X_RES % 8 != 0) || (Y_RES % 8 != 0)) begin : g_bad_cfg
        $error("hdmi_blk_buf_ctrl: N must divide 8, X_RES and Y_RES must be multiples of 8");
    end

    typedef enum logic {IDLE, READ} state_t;
    state_t        state;

    logic          vs_prev;
    logic [CW-1:0] col;
    logic [2:0]    row;
    logic          wr_bank, drop, sof_pend;
    logic [1:0]    bank_full, bank_sof, bank_full_nxt;
    logic          rd_cur;
    logic [WW-1:0] rw;
    logic [2:0]    rr;
    logic [BW-1:0] rb;
    logic          rd_en_q, rd_bank_q, sob_i, eob_i, sof_i;
    logic [AW-1:0] rd_addr_q;
    logic          blk_valid_q, blk_sob_q, blk_eob_q, blk_sof_q, ovf_q;

    logic vs_edge, beat, band_start, drop_now, col_last, band_done;
    logic issue, rw_last, rr_last, rb_last, rd_done;

    assign vs_edge    = bus.en & bus.hdmi_v_sync & ~vs_prev;
    assign beat       = bus.en & bus.hdmi_data_valid & ~vs_edge;
    assign band_start = (row == 3'd0) && (col == '0);
    // The drop decision is taken on the first beat of a band and then held by the drop register.
    assign drop_now   = band_start ? bank_full[wr_bank] : drop;
    assign col_last   = (col == CW'(W - 1));
    assign band_done  = beat & col_last & (row == 3'd7);

    assign issue      = bus.en & (state == READ) & bus.blk_ready & ~vs_edge;
    assign rw_last    = (rw == WW'(WPB - 1));
    assign rr_last    = (rr == 3'd7);
    assign rb_last    = (rb == BW'(NB - 1));
    assign rd_done    = issue & rw_last & rr_last & rb_last;

    assign bus.wr_en     = beat & ~drop_now;
    assign bus.wr_bank   = wr_bank;
    assign bus.wr_addr   = AW'(row) * AW'(W) + AW'(col);
    assign bus.rd_en     = rd_en_q & bus.en;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_sob   = blk_sob_q;
    assign bus.blk_eob   = blk_eob_q;
    assign bus.blk_sof   = blk_sof_q;
    assign bus.ovf_err   = ovf_q;

    // Writer fill and reader drain touch different banks, so both updates can land together.
    always_comb begin
        bank_full_nxt = bank_full;
        if (band_done && !drop_now) bank_full_nxt[wr_bank] = 1'b1;
        if (rd_done)                bank_full_nxt[rd_cur]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vs_prev     <= 1'b0;
            col         <= '0;
            row         <= '0;
            wr_bank     <= 1'b0;
            drop        <= 1'b0;
            sof_pend    <= 1'b0;
            bank_full   <= '0;
            bank_sof    <= '0;
            rd_cur      <= 1'b0;
            rw          <= '0;
            rr          <= '0;
            rb          <= '0;
            rd_en_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            sob_i       <= 1'b0;
            eob_i       <= 1'b0;
            sof_i       <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_sob_q   <= 1'b0;
            blk_eob_q   <= 1'b0;
            blk_sof_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (bus.en) begin
            vs_prev     <= bus.hdmi_v_sync;
            rd_en_q     <= issue;
            blk_valid_q <= rd_en_q;
            blk_sob_q   <= rd_en_q & sob_i;
            blk_eob_q   <= rd_en_q & eob_i;
            blk_sof_q   <= rd_en_q & sof_i;
            if (vs_edge) begin
                state     <= IDLE;
                col       <= '0;
                row       <= '0;
                wr_bank   <= 1'b0;
                drop      <= 1'b0;
                sof_pend  <= 1'b1;
                bank_full <= '0;
                bank_sof  <= '0;
                rd_cur    <= 1'b0;
                rw        <= '0;
                rr        <= '0;
                rb        <= '0;
                ovf_q     <= 1'b0;
            end else begin
                bank_full <= bank_full_nxt;
                if (beat) begin
                    if (band_start) begin
                        drop <= bank_full[wr_bank];
                        if (bank_full[wr_bank]) ovf_q <= 1'b1;
                    end
                    if (col_last) begin
                        col <= '0;
                        row <= row + 3'd1;
                        // A dropped band leaves the bank pointer alone so writer and reader stay in step.
                        if (row == 3'd7 && !drop_now) begin
                            bank_sof[wr_bank] <= sof_pend;
                            sof_pend          <= 1'b0;
                            wr_bank           <= ~wr_bank;
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end else if (bus.hdmi_h_sync && col != '0) begin
                    col <= '0;
                end

                if (issue) begin
                    rd_addr_q <= AW'(rr) * AW'(W) + AW'(rb) * AW'(WPB) + AW'(rw);
                    rd_bank_q <= rd_cur;
                    sob_i     <= (rr == 3'd0) && (rw == '0);
                    eob_i     <= rr_last && rw_last;
                    sof_i     <= (rr == 3'd0) && (rw == '0) && (rb == '0) && bank_sof[rd_cur];
                    if (rw_last) begin
                        rw <= '0;
                        rr <= rr + 3'd1;
                        if (rr_last) rb <= rb_last ? '0 : rb + BW'(1);
                    end else begin
                        rw <= rw + WW'(1);
                    end
                end

                case (state)
                    IDLE: if (bank_full[rd_cur]) state <= READ;
                    READ: if (rd_done) begin
                        state  <= IDLE;
                        rd_cur <= ~rd_cur;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hdmi_blk_buf_ctrl.sv
// Directed bench for the ping-pong block buffer sequencer at X_RES=16, Y_RES=16, N=2
// (8 words/line, 64 words/bank, 32 read beats per 8x8 block).
module tb_hdmi_blk_buf_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdmi_blk_buf_ctrl_if #(.AW(6)) bus ();
    hdmi_blk_buf_ctrl #(.N(2), .X_RES(16), .Y_RES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [6:0] wr_q[$];
    logic [6:0] rd_q[$];
    logic [2:0] fl_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) wr_q.push_back({bus.wr_bank, bus.wr_addr});
            if (bus.rd_en) rd_q.push_back({bus.rd_bank, bus.rd_addr});
            if (bus.blk_valid && bus.en) fl_q.push_back({bus.blk_sob, bus.blk_eob, bus.blk_sof});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Expected {bank, addr} of the i-th write: banks alternate every 64 words, raster order.
    function automatic logic [6:0] exp_wr(input int i);
        return {1'(i / 64), 6'(i % 64)};
    endfunction

    // Expected {bank, addr} of the i-th read: w fastest (4), then row (8), then block (2).
    function automatic logic [6:0] exp_rd(input int i);
        int j;
        j = i % 64;
        return {1'(i / 64), 6'(((j % 32) / 4) * 8 + (j / 32) * 4 + (j % 4))};
    endfunction

    function automatic logic [2:0] exp_fl(input int i, input bit sof);
        int j;
        j = i % 32;
        return {(j == 0), (j == 31), (sof && i == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wr_q.delete();
        rd_q.delete();
        fl_q.delete();
    endtask

    task automatic vs_pulse();
        bus.hdmi_v_sync = 1'b1;
        tick();
        bus.hdmi_v_sync = 1'b0;
    endtask

    // Beats first..last-1 of a frame stream; h_sync follows each completed 8-beat line.
    task automatic send_beats(input int first, input int last);
        for (int k = first; k < last; k++) begin
            bus.hdmi_data_valid = 1'b1;
            tick();
            if (k % 8 == 7) begin
                bus.hdmi_data_valid = 1'b0;
                bus.hdmi_h_sync     = 1'b1;
                tick();
                bus.hdmi_h_sync     = 1'b0;
            end
        end
        bus.hdmi_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_cnt++;
        if ({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.rd_en, bus.rd_bank, bus.rd_addr, bus.blk_valid,
             bus.blk_sob, bus.blk_eob, bus.blk_sof, bus.ovf_err} !== 22'h0)
            $display("FAIL reset_outputs: wr_addr %h rd_addr %h rd_en %b ovf %b, all want 0",
                     bus.wr_addr, bus.rd_addr, bus.rd_en, bus.ovf_err);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.blk_valid !== 1'b0 || bus.ovf_err !== 1'b0) bad++;
            tick();
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_single_band();
        int n, bad;
        bus.blk_ready       = 1'b1;
        bus.hdmi_v_sync     = 1'b1;
        bus.hdmi_data_valid = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.wr_en !== 1'b0) $display("FAIL vs_beat_ignored: wr_en %b want 0", bus.wr_en);
        else pass_cnt++;
        tick();
        bus.hdmi_v_sync     = 1'b0;
        bus.hdmi_data_valid = 1'b0;
        clear_q();
        send_beats(0, 64);
        n = 0;
        while (fl_q.size() < 64 && n < 300) begin tick(); n++; end
        repeat (5) tick();

        bad = -1;
        foreach (wr_q[i]) if (bad < 0 && wr_q[i] !== exp_wr(i)) bad = i;
        chk_cnt++;
        if (wr_q.size() != 64 || bad >= 0)
            $display("FAIL single_wr: size %0d want 64, idx %0d got %h want %h", wr_q.size(), bad,
                     (bad >= 0) ? wr_q[bad] : 7'h0, (bad >= 0) ? exp_wr(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== exp_rd(i)) bad = i;
        chk_cnt++;
        if (rd_q.size() != 64 || bad >= 0)
            $display("FAIL single_rd: size %0d want 64, idx %0d got %h want %h", rd_q.size(), bad,
                     (bad >= 0) ? rd_q[bad] : 7'h0, (bad >= 0) ? exp_rd(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (fl_q[i]) if (bad < 0 && fl_q[i] !== exp_fl(i, 1'b1)) bad = i;
        chk_cnt++;
        if (fl_q.size() != 64 || bad >= 0)
            $display("FAIL single_flags: size %0d want 64, idx %0d got %b want %b", fl_q.size(), bad,
                     (bad >= 0) ? fl_q[bad] : 3'b0, (bad >= 0) ? exp_fl(bad, 1'b1) : 3'b0);
        else pass_cnt++;
    endtask

    task automatic test_two_bands();
        int n, bad;
        bus.blk_ready = 1'b1;
        vs_pulse();
        clear_q();
        send_beats(0, 128);
        n = 0;
        while (fl_q.size() < 128 && n < 400) begin tick(); n++; end
        repeat (5) tick();

        bad = -1;
        foreach (wr_q[i]) if (bad < 0 && wr_q[i] !== exp_wr(i)) bad = i;
        chk_cnt++;
        if (wr_q.size() != 128 || bad >= 0)
            $display("FAIL two_wr: size %0d want 128, idx %0d got %h want %h", wr_q.size(), bad,
                     (bad >= 0) ? wr_q[bad] : 7'h0, (bad >= 0) ? exp_wr(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== exp_rd(i)) bad = i;
        chk_cnt++;
        if (rd_q.size() != 128 || bad >= 0)
            $display("FAIL two_rd: size %0d want 128, idx %0d got %h want %h", rd_q.size(), bad,
                     (bad >= 0) ? rd_q[bad] : 7'h0, (bad >= 0) ? exp_rd(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (fl_q[i]) if (bad < 0 && fl_q[i] !== exp_fl(i, 1'b1)) bad = i;
        chk_cnt++;
        if (fl_q.size() != 128 || bad >= 0)
            $display("FAIL two_flags: size %0d want 128, idx %0d got %b want %b", fl_q.size(), bad,
                     (bad >= 0) ? fl_q[bad] : 3'b0, (bad >= 0) ? exp_fl(bad, 1'b1) : 3'b0);
        else pass_cnt++;

        chk_cnt++;
        if (bus.ovf_err !== 1'b0) $display("FAIL two_ovf: ovf_err %b want 0", bus.ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int n, bad;
        bus.blk_ready = 1'b0;
        vs_pulse();
        clear_q();
        send_beats(0, 192);
        repeat (5) tick();

        bad = -1;
        foreach (wr_q[i]) if (bad < 0 && wr_q[i] !== exp_wr(i)) bad = i;
        chk_cnt++;
        if (wr_q.size() != 128 || bad >= 0)
            $display("FAIL ovf_wr: size %0d want 128, idx %0d got %h want %h", wr_q.size(), bad,
                     (bad >= 0) ? wr_q[bad] : 7'h0, (bad >= 0) ? exp_wr(bad) : 7'h0);
        else pass_cnt++;

        chk_cnt++;
        if (rd_q.size() != 0 || bus.ovf_err !== 1'b1)
            $display("FAIL ovf_flag: reads %0d want 0, ovf_err %b want 1", rd_q.size(), bus.ovf_err);
        else pass_cnt++;

        bus.blk_ready = 1'b1;
        n = 0;
        while (fl_q.size() < 128 && n < 400) begin tick(); n++; end
        repeat (5) tick();

        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== exp_rd(i)) bad = i;
        chk_cnt++;
        if (rd_q.size() != 128 || bad >= 0)
            $display("FAIL ovf_drain: size %0d want 128, idx %0d got %h want %h", rd_q.size(), bad,
                     (bad >= 0) ? rd_q[bad] : 7'h0, (bad >= 0) ? exp_rd(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (fl_q[i]) if (bad < 0 && fl_q[i] !== exp_fl(i, 1'b1)) bad = i;
        chk_cnt++;
        if (fl_q.size() != 128 || bad >= 0 || bus.ovf_err !== 1'b1)
            $display("FAIL ovf_drain_flags: size %0d want 128, idx %0d, ovf_err %b want 1",
                     fl_q.size(), bad, bus.ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_vsync_mid_read();
        int n, bad;
        bus.blk_ready = 1'b0;
        vs_pulse();
        send_beats(0, 192);
        chk_cnt++;
        if (bus.ovf_err !== 1'b1) $display("FAIL midvs_pre_ovf: ovf_err %b want 1", bus.ovf_err);
        else pass_cnt++;

        clear_q();
        bus.blk_ready = 1'b1;
        n = 0;
        while (rd_q.size() < 10 && n < 100) begin tick(); n++; end
        vs_pulse();
        @(negedge clk);
        chk_cnt++;
        if (bus.rd_en !== 1'b0 || bus.ovf_err !== 1'b0)
            $display("FAIL midvs_stop: rd_en %b want 0, ovf_err %b want 0", bus.rd_en, bus.ovf_err);
        else pass_cnt++;
        tick();
        clear_q();
        repeat (20) tick();
        chk_cnt++;
        if (rd_q.size() != 0 || fl_q.size() != 0)
            $display("FAIL midvs_banks_cleared: reads %0d flags %0d want 0", rd_q.size(), fl_q.size());
        else pass_cnt++;

        send_beats(0, 64);
        n = 0;
        while (fl_q.size() < 64 && n < 300) begin tick(); n++; end
        repeat (5) tick();

        bad = -1;
        foreach (wr_q[i]) if (bad < 0 && wr_q[i] !== exp_wr(i)) bad = i;
        chk_cnt++;
        if (wr_q.size() != 64 || bad >= 0)
            $display("FAIL midvs_wr: size %0d want 64, idx %0d got %h want %h", wr_q.size(), bad,
                     (bad >= 0) ? wr_q[bad] : 7'h0, (bad >= 0) ? exp_wr(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== exp_rd(i)) bad = i;
        foreach (fl_q[i]) if (bad < 0 && fl_q[i] !== exp_fl(i, 1'b1)) bad = 100 + i;
        chk_cnt++;
        if (rd_q.size() != 64 || fl_q.size() != 64 || bad >= 0)
            $display("FAIL midvs_rd_sof: reads %0d flags %0d want 64, first bad %0d (100+ = flags)",
                     rd_q.size(), fl_q.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_enable_freeze();
        int n, bad;
        bus.blk_ready = 1'b1;
        vs_pulse();
        clear_q();
        send_beats(0, 28);
        bus.en              = 1'b0;
        bus.hdmi_data_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_addr !== 6'd28) bad++;
            tick();
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL freeze_wr: %0d bad cycles (wr_addr %0d want 28, no strobes)", bad, bus.wr_addr);
        else pass_cnt++;
        bus.en = 1'b1;
        send_beats(28, 64);

        n = 0;
        while (rd_q.size() < 10 && n < 100) begin tick(); n++; end
        bus.en = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.rd_en !== 1'b0 || bus.rd_addr !== 6'd18 || bus.blk_valid !== 1'b1) bad++;
            tick();
        end
        chk_cnt++;
        if (bad != 0)
            $display("FAIL freeze_rd: %0d bad cycles, rd_addr %0d want 18, blk_valid %b want 1",
                     bad, bus.rd_addr, bus.blk_valid);
        else pass_cnt++;
        bus.en = 1'b1;
        n = 0;
        while (fl_q.size() < 64 && n < 300) begin tick(); n++; end
        repeat (5) tick();

        bad = -1;
        foreach (wr_q[i]) if (bad < 0 && wr_q[i] !== exp_wr(i)) bad = i;
        chk_cnt++;
        if (wr_q.size() != 64 || bad >= 0)
            $display("FAIL freeze_wr_seq: size %0d want 64, idx %0d got %h want %h", wr_q.size(), bad,
                     (bad >= 0) ? wr_q[bad] : 7'h0, (bad >= 0) ? exp_wr(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== exp_rd(i)) bad = i;
        chk_cnt++;
        if (rd_q.size() != 64 || bad >= 0)
            $display("FAIL freeze_rd_seq: size %0d want 64, idx %0d got %h want %h", rd_q.size(), bad,
                     (bad >= 0) ? rd_q[bad] : 7'h0, (bad >= 0) ? exp_rd(bad) : 7'h0);
        else pass_cnt++;

        bad = -1;
        foreach (fl_q[i]) if (bad < 0 && fl_q[i] !== exp_fl(i, 1'b1)) bad = i;
        chk_cnt++;
        if (fl_q.size() != 64 || bad >= 0)
            $display("FAIL freeze_flags: size %0d want 64, idx %0d got %b want %b", fl_q.size(), bad,
                     (bad >= 0) ? fl_q[bad] : 3'b0, (bad >= 0) ? exp_fl(bad, 1'b1) : 3'b0);
        else pass_cnt++;
    endtask

    initial begin
        bus.en              = 1'b1;
        bus.hdmi_v_sync     = 1'b0;
        bus.hdmi_h_sync     = 1'b0;
        bus.hdmi_data_valid = 1'b0;
        bus.blk_ready       = 1'b0;
        test_reset();
        test_single_band();
        test_two_bands();
        test_overflow();
        test_vsync_mid_read();
        test_enable_freeze();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
